inst_fetch_queue: RTL and testbench

- Initiator side of the instruction-memory read port: owns the fetch PC, drives the word address, captures the returned instruction word with its PC into a small prefetch FIFO.
- Presents a valid/ready stream of {pc, instruction} to decode.
- Accepts a redirect (branch/jump resolution or predictor target) that flushes queued words and restarts fetch at the new PC.
- Sits between the PC/branch-prediction logic and the decode stage of the pipelined core.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/inst_fetch_queue.sv | 78 +++++++
 tb/tb_inst_fetch_queue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Types and constants shared by the instruction fetch path: the fetch entry
// record, the NOP filler and the PC increment.
package cpu_pkg;

    localparam int INST_W = 32;
    localparam int PC_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instruction} entries. Flush clears it in one edge,
// and the head entry is read combinationally.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  fetch_entry_t           push_data,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    // Occupancy guards keep count inside 0..DEPTH even if a caller misbehaves.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count < CNT_W'(DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, reads instruction memory
// and feeds decode through a small prefetch FIFO with redirect flush.
module inst_fetch_queue
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDR_W-1:0]        inst_address,
    input  logic [INST_W-1:0]        instruction,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              deq;
    logic              enq;
    fetch_entry_t      push_data;
    fetch_entry_t      head;

    assign inst_address     = fetch_pc;
    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

    assign out_valid = (count != '0);
    assign deq       = out_valid && out_ready;
    assign enq       = !redirect_valid && ((count < CNT_W'(DEPTH)) || deq);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC[ADDR_W-1:0];
        end else if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
        end else if (enq) begin
            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        end
    end

    always_comb begin
        push_data      = '0;
        push_data.pc   = PC_W'(fetch_pc);
        push_data.inst = instruction;
    end

    // A dequeue coinciding with a redirect is consumed but flushed along with the rest.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (enq),
        .pop       (deq && !redirect_valid),
        .push_data (push_data),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        out_pc   = '0;
        out_inst = NOP_INST;
        if (out_valid) begin
            out_pc   = ADDR_W'(head.pc);
            out_inst = head.inst;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table for the corner cases,
// then randomized traffic against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_address;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int vectors;
    int miscompares;

    inst_fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_address   (inst_address),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return BASE + {23'd0, addr[10:2]};
    endfunction

    assign instruction = mem_word(inst_address);

    typedef struct {
        logic        rst_n;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic [2:0]  ecnt;
        logic [31:0] eaddr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    vec_t tbl [25];
    ent_t mq[$];
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] epc,
                             input logic [31:0] einst, input logic [2:0] ecnt,
                             input logic [31:0] eaddr);
        vectors++;
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, ".out_pc"}, out_pc, epc);
        chk({tag, ".out_inst"}, out_inst, einst);
        chk({tag, ".count"}, {29'd0, count}, {29'd0, ecnt});
        chk({tag, ".inst_address"}, inst_address, eaddr);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        //            rst redir rpc            rdy  ev  epc            einst        cnt  eaddr
        tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         NOP,         3'd0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         BASE,        3'd1, 32'h4};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         BASE,        3'd2, 32'h8};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         BASE,        3'd3, 32'hC};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         BASE,        3'd4, 32'h10};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         BASE,        3'd4, 32'h10};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         BASE,        3'd4, 32'h10};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         BASE + 1,    3'd4, 32'h14};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         BASE + 1,    3'd4, 32'h14};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         NOP,         3'd0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         BASE,        3'd1, 32'h4};
        tbl[11] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         BASE,        3'd2, 32'h8};
        tbl[12] = '{1'b1, 1'b1, 32'h102,       1'b0, 1'b1, 32'h0,         BASE,        3'd3, 32'hC};
        tbl[13] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         NOP,         3'd0, 32'h100};
        tbl[14] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h100,       BASE + 32'h40, 3'd1, 32'h104};
        tbl[15] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       BASE + 32'h40, 3'd2, 32'h108};
        tbl[16] = '{1'b1, 1'b1, 32'h40,        1'b1, 1'b1, 32'h104,       BASE + 32'h41, 3'd2, 32'h10C};
        tbl[17] = '{1'b1, 1'b1, 32'h80,        1'b1, 1'b0, 32'h0,         NOP,         3'd0, 32'h40};
        tbl[18] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         NOP,         3'd0, 32'h80};
        tbl[19] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h80,        BASE + 32'h20, 3'd1, 32'h84};
        tbl[20] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h84,        BASE + 32'h21, 3'd1, 32'h88};
        tbl[21] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         NOP,         3'd0, 32'hFFFF_FFFC};
        tbl[22] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, BASE + 32'h1FF, 3'd1, 32'h0};
        tbl[23] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         BASE,        3'd1, 32'h4};
        tbl[24] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         BASE + 1,    3'd1, 32'h8};

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            rst_n          = tbl[i].rst_n;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            out_ready      = tbl[i].ready;
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].einst,
                      tbl[i].ecnt, tbl[i].eaddr);
        end

        // Hand sequence: redirect while full and stalled drops every entry.
        @(negedge clk);
        rst_n = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check_all("full_redirect", 1'b0, 32'h0, NOP, 3'd0, 32'h200);

        // Randomized phase: reset once so the model starts in a known state.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        mq.delete();
        m_pc = 32'h0;
        for (int c = 0; c < 600; c++) begin
            logic exp_v;
            logic [31:0] exp_pc;
            logic [31:0] exp_inst;
            @(negedge clk);
            rst_n          = ($urandom_range(0, 49) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                         : $urandom;
            out_ready      = $urandom_range(0, 1) == 1;
            #1;
            exp_v    = (mq.size() != 0);
            exp_pc   = exp_v ? mq[0].pc : 32'h0;
            exp_inst = exp_v ? mq[0].inst : NOP;
            check_all($sformatf("rnd%0d", c), exp_v, exp_pc, exp_inst, 3'(mq.size()), m_pc);
            @(posedge clk);
            if (!rst_n) begin
                mq.delete();
                m_pc = 32'h0;
            end else if (redirect_valid) begin
                mq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (out_ready && mq.size() != 0) begin
                    void'(mq.pop_front());
                end
                if (mq.size() < 4) begin
                    mq.push_back('{pc: m_pc, inst: mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
